if_hazard_ctrl: RTL and testbench

IF_HAZARD_CTRL -- requirements
Module: if_hazard_ctrl

---
 rtl/if_hazard_ctrl.sv | 157 +++++++++++++++
 tb/tb_if_hazard_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/if_hazard_ctrl.sv
// Fetch-side hazard controller: load-use stalls, branch redirects and
// instruction-memory wait handling with a pending-redirect slot and fetch timeout.
module if_hazard_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  id_opcode,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rt,
    input  logic        ex_branch_taken,
    input  logic [31:0] ex_target,
    input  logic        imem_ready,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        pcsrc,
    output logic [31:0] if_a,
    output logic [15:0] stall_count,
    output logic        fetch_err,
    output logic        ctrl_state
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned STL_W  = 16;
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t              state, state_n;
    logic                pend_valid, pend_valid_n;
    logic [ADDR_W-1:0]   pend_target, pend_target_n;
    logic [CNT_W-1:0]    wait_cnt, wait_cnt_n;
    logic                uses_rt;
    logic                load_use;
    logic                fetch_err_set;

    // Instructions that read rt as a source operand
    always_comb begin
        case (id_opcode)
            6'h00, 6'h04, 6'h05, 6'h2B: uses_rt = 1'b1;
            default:                    uses_rt = 1'b0;
        endcase
    end

    assign load_use = ex_memread & (ex_rt != 5'd0) &
                      ((ex_rt == id_rs) | ((ex_rt == id_rt) & uses_rt));

    // Next-state and control outputs
    always_comb begin
        pc_write      = 1'b1;
        ifid_write    = 1'b1;
        ifid_flush    = 1'b0;
        idex_flush    = 1'b0;
        pcsrc         = 1'b0;
        if_a          = '0;
        state_n       = state;
        pend_valid_n  = pend_valid;
        pend_target_n = pend_target;
        wait_cnt_n    = wait_cnt;

        case (state)
            ST_RUN: begin
                if (ex_branch_taken) begin
                    pcsrc      = 1'b1;
                    if_a       = ex_target;
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (load_use) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                end else if (!imem_ready) begin
                    pc_write   = 1'b0;
                    ifid_flush = 1'b1;
                    state_n    = ST_WAIT;
                    wait_cnt_n = '0;
                end
            end
            ST_WAIT: begin
                if (!imem_ready) begin
                    pc_write   = 1'b0;
                    ifid_flush = 1'b1;
                    if (wait_cnt != {CNT_W{1'b1}}) begin
                        wait_cnt_n = wait_cnt + CNT_W'(1);
                    end
                    // Only the first branch seen while waiting is remembered
                    if (ex_branch_taken && !pend_valid) begin
                        pend_valid_n  = 1'b1;
                        pend_target_n = ex_target;
                        idex_flush    = 1'b1;
                    end
                end else if (pend_valid) begin
                    pcsrc        = 1'b1;
                    if_a         = pend_target;
                    ifid_flush   = 1'b1;
                    pend_valid_n = 1'b0;
                    state_n      = ST_RUN;
                end else if (ex_branch_taken) begin
                    pcsrc      = 1'b1;
                    if_a       = ex_target;
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    state_n    = ST_RUN;
                end else begin
                    state_n = ST_RUN;
                end
            end
            default: state_n = ST_RUN;
        endcase

        // Hold the pipeline frozen and flushed while in reset
        if (!reset) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            pcsrc      = 1'b0;
            if_a       = '0;
        end
    end

    assign fetch_err_set = (state == ST_WAIT) &&
                           ((wait_cnt == TIMEOUT_CNT) || (wait_cnt_n == TIMEOUT_CNT));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_RUN;
            pend_valid  <= 1'b0;
            pend_target <= '0;
            wait_cnt    <= '0;
            stall_count <= '0;
            fetch_err   <= 1'b0;
        end else begin
            state       <= state_n;
            pend_valid  <= pend_valid_n;
            pend_target <= pend_target_n;
            wait_cnt    <= wait_cnt_n;
            if (!pc_write && (stall_count != {STL_W{1'b1}})) begin
                stall_count <= stall_count + STL_W'(1);
            end
            if (fetch_err_set) begin
                fetch_err <= 1'b1;
            end
        end
    end

    assign ctrl_state = state;

endmodule

// File: tb/tb_if_hazard_ctrl.sv
// Directed self-checking bench for if_hazard_ctrl.
module tb_if_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  id_opcode;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        ex_memread;
    logic [4:0]  ex_rt;
    logic        ex_branch_taken;
    logic [31:0] ex_target;
    logic        imem_ready;
    logic        pc_write;
    logic        ifid_write;
    logic        ifid_flush;
    logic        idex_flush;
    logic        pcsrc;
    logic [31:0] if_a;
    logic [15:0] stall_count;
    logic        fetch_err;
    logic        ctrl_state;

    int checks   = 0;
    int failures = 0;

    if_hazard_ctrl #(.TIMEOUT(255)) dut (
        .clk            (clk),
        .reset          (reset),
        .id_opcode      (id_opcode),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .ex_memread     (ex_memread),
        .ex_rt          (ex_rt),
        .ex_branch_taken(ex_branch_taken),
        .ex_target      (ex_target),
        .imem_ready     (imem_ready),
        .pc_write       (pc_write),
        .ifid_write     (ifid_write),
        .ifid_flush     (ifid_flush),
        .idex_flush     (idex_flush),
        .pcsrc          (pcsrc),
        .if_a           (if_a),
        .stall_count    (stall_count),
        .fetch_err      (fetch_err),
        .ctrl_state     (ctrl_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs are then driven 1ns after it
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_opcode       = 6'h23;
        id_rs           = 5'd1;
        id_rt           = 5'd2;
        ex_memread      = 1'b0;
        ex_rt           = 5'd9;
        ex_branch_taken = 1'b0;
        ex_target       = 32'h0;
        imem_ready      = 1'b1;
    endtask

    // Control bundle: {pc_write, ifid_write, ifid_flush, idex_flush, pcsrc}
    function automatic logic [31:0] ctl();
        return {27'd0, pc_write, ifid_write, ifid_flush, idex_flush, pcsrc};
    endfunction

    initial begin
        idle();
        reset = 1'b0;
        #12;
        check("rst_ctl",   ctl(), 32'b00110);
        check("rst_if_a",  if_a, 32'h0);
        check("rst_stall", 32'(stall_count), 32'd0);
        check("rst_err",   32'(fetch_err), 32'd0);
        check("rst_state", 32'(ctrl_state), 32'd0);

        cyc(); reset = 1'b1; #1;
        check("run_default", ctl(), 32'b11000);

        // Load-use on rs
        ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; #1;
        check("lu_ctl", ctl(), 32'b00010);
        cyc();
        check("lu_stall", 32'(stall_count), 32'd1);

        // rt==0 never hazards; load consumer (0x23) does not read rt
        ex_rt = 5'd0; id_rs = 5'd0; #1;
        check("lu_r0", ctl(), 32'b11000);
        ex_rt = 5'd7; id_rs = 5'd3; id_rt = 5'd7; id_opcode = 6'h23; #1;
        check("lu_lw_rt", ctl(), 32'b11000);
        id_opcode = 6'h2B; #1;
        check("lu_sw_rt", ctl(), 32'b00010);
        cyc();
        check("lu_sw_stall", 32'(stall_count), 32'd2);

        // Branch beats load-use and a not-ready fetch
        ex_branch_taken = 1'b1; ex_target = 32'h40; imem_ready = 1'b0; #1;
        check("br_ctl",  ctl(), 32'b11111);
        check("br_if_a", if_a, 32'h40);
        cyc();
        check("br_state", 32'(ctrl_state), 32'd0);
        check("br_stall", 32'(stall_count), 32'd2);

        // Wait with a branch captured in its second cycle
        idle(); imem_ready = 1'b0; #1;
        check("w1_ctl", ctl(), 32'b01100);
        cyc();
        check("w1_state", 32'(ctrl_state), 32'd1);
        ex_branch_taken = 1'b1; ex_target = 32'h80; #1;
        check("w2_ctl", ctl(), 32'b01110);
        cyc();
        ex_target = 32'hC0; #1;
        check("w3_ignore", ctl(), 32'b01100);
        cyc();
        ex_branch_taken = 1'b0; imem_ready = 1'b1; #1;
        check("w_rdy_ctl",  ctl(), 32'b11101);
        check("w_rdy_if_a", if_a, 32'h80);
        cyc();
        check("w_back_run", 32'(ctrl_state), 32'd0);
        check("w_stall",    32'(stall_count), 32'd5);
        check("w_no_redir", ctl(), 32'b11000);

        // Timeout: clear counters, then 256 cycles of not-ready
        reset = 1'b0; #1; reset = 1'b1;
        idle(); imem_ready = 1'b0;
        for (int i = 0; i < 255; i++) cyc();
        check("to_err_255", 32'(fetch_err), 32'd0);
        cyc();
        check("to_err_256", 32'(fetch_err), 32'd1);
        check("to_stall",   32'(stall_count), 32'd256);
        imem_ready = 1'b1;
        cyc();
        check("to_err_hold",  32'(fetch_err), 32'd1);
        check("to_state_run", 32'(ctrl_state), 32'd0);

        // Reset mid-wait with a pending redirect
        imem_ready = 1'b0;
        cyc();
        ex_branch_taken = 1'b1; ex_target = 32'h100;
        cyc();
        ex_branch_taken = 1'b0;
        check("rw_pre_state", 32'(ctrl_state), 32'd1);
        #2; reset = 1'b0; #1;
        check("rw_state", 32'(ctrl_state), 32'd0);
        check("rw_err",   32'(fetch_err), 32'd0);
        check("rw_stall", 32'(stall_count), 32'd0);
        check("rw_ctl",   ctl(), 32'b00110);
        cyc(); reset = 1'b1; imem_ready = 1'b1; #1;
        check("rw_after_ctl",  ctl(), 32'b11000);
        check("rw_after_if_a", if_a, 32'h0);
        cyc();
        check("rw_after2_ctl", ctl(), 32'b11000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
